// File: rtl/fetch_pkg.sv
// Shared fetch constants: word values, PC step, FSM encodings.
// Imported by the fetch unit and its skid buffer.
package fetch_pkg;

  localparam logic [31:0] WORD_ZERO        = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;
  localparam logic [31:0] BUBBLE_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction+PC buffer; holds a fetched word while
// decode is stalled. Clear has priority over load.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc
);

  logic              r_valid;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= WORD_W'(WORD_ZERO);
      r_pc    <= WORD_W'(WORD_ZERO);
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_instr <= WORD_W'(WORD_ZERO);
      r_pc    <= WORD_W'(WORD_ZERO);
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller around the PC register: drives
// pc_d, the imem req/ack handshake and the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              WORD_W       = 32,
  parameter logic [WORD_W-1:0] BUBBLE_INSTR = WORD_W'(BUBBLE_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_q,
  output logic [WORD_W-1:0] pc_d,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_pc4
);

  fetch_state_e      r_state;
  logic [WORD_W-1:0] r_pend;
  logic              r_ifid_valid;
  logic [WORD_W-1:0] r_ifid_instr;
  logic [WORD_W-1:0] r_ifid_pc;
  logic [WORD_W-1:0] r_ifid_pc4;

  logic [WORD_W-1:0] w_pc4;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [WORD_W-1:0] w_skid_instr;
  logic [WORD_W-1:0] w_skid_pc;
  logic [WORD_W-1:0] w_skid_pc4;

  assign w_pc4      = pc_q + WORD_W'(PC_INCREMENT);
  assign w_skid_pc4 = w_skid_pc + WORD_W'(PC_INCREMENT);

  assign imem_addr = pc_q;
  assign imem_req  = (r_state == FETCH_REQ) ||
                     (r_state == FETCH_DRAIN);

  assign w_skid_load  = (r_state == FETCH_REQ) && imem_ack &&
                        stall && !redirect_valid;
  assign w_skid_clear = (r_state == FETCH_HOLD) &&
                        (redirect_valid || !stall);

  fetch_skid #(.WORD_W(WORD_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (pc_q),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (r_state)
      FETCH_IDLE: begin
        if (redirect_valid) pc_d = redirect_target;
      end
      FETCH_REQ: begin
        if (imem_ack && redirect_valid) pc_d = redirect_target;
        else if (imem_ack)              pc_d = w_pc4;
      end
      FETCH_DRAIN: begin
        if (imem_ack)
          pc_d = redirect_valid ? redirect_target : r_pend;
      end
      FETCH_HOLD: begin
        if (redirect_valid) pc_d = redirect_target;
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH_IDLE;
      r_pend       <= WORD_W'(WORD_ZERO);
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= BUBBLE_INSTR;
      r_ifid_pc    <= WORD_W'(WORD_ZERO);
      r_ifid_pc4   <= WORD_W'(WORD_ZERO);
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          r_state <= FETCH_REQ;
          if (redirect_valid) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
          end
        end
        FETCH_REQ: begin
          if (redirect_valid) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
            if (imem_ack) begin
              r_state <= FETCH_REQ;
            end else begin
              r_state <= FETCH_DRAIN;
              r_pend  <= redirect_target;
            end
          end else if (imem_ack && !stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= imem_rdata;
            r_ifid_pc    <= pc_q;
            r_ifid_pc4   <= w_pc4;
          end else if (imem_ack) begin
            r_state <= FETCH_HOLD;
          end else if (!stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
          end
        end
        FETCH_DRAIN: begin
          // the stale word still has to be absorbed before refetching
          if (redirect_valid && !imem_ack) r_pend <= redirect_target;
          if (imem_ack) r_state <= FETCH_REQ;
          if (redirect_valid || !stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
          end
        end
        FETCH_HOLD: begin
          if (redirect_valid) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
            r_state      <= FETCH_REQ;
          end else if (!stall) begin
            r_ifid_valid <= w_skid_valid;
            r_ifid_instr <= w_skid_instr;
            r_ifid_pc    <= w_skid_pc;
            r_ifid_pc4   <= w_skid_pc4;
            r_state      <= FETCH_REQ;
          end
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, async reset sequence,
// then random stall/redirect/latency against a fetch-stream model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  logic        use_model;
  logic        tb_ack;
  int          m_wait;
  int          m_lat;

  int n_err;
  int n_chk;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_q            (pc_q),
    .pc_d            (pc_d),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc4        (ifid_pc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // PC register sits outside the fetch unit
  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'h0;
    else     pc_q <= pc_d;
  end

  // memory with a fresh random latency (0..3) per request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 0;
      m_lat  <= 0;
    end else if (imem_ack) begin
      m_wait <= 0;
      m_lat  <= int'($urandom_range(3, 0));
    end else if (imem_req) begin
      m_wait <= m_wait + 1;
    end
  end

  assign imem_ack   = use_model ? (imem_req && (m_wait >= m_lat)) : tb_ack;
  assign imem_rdata = memf(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rdv;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] pcd;
  } row_t;

  function automatic row_t mk(input logic s, input logic r,
                              input logic [31:0] t, input logic a,
                              input logic q, input logic [31:0] ad,
                              input logic v, input logic [31:0] ip,
                              input logic [31:0] pd);
    row_t x;
    x.stall = s; x.rdv = r; x.tgt = t; x.ack = a;
    x.req = q; x.addr = ad; x.vld = v; x.ipc = ip; x.pcd = pd;
    return x;
  endfunction

  row_t tbl[24];

  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;
  int          delivered;

  initial begin
    n_err = 0;
    n_chk = 0;
    use_model = 1'b0;
    tb_ack = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    rst = 1'b1;

    //        stall rdv tgt           ack | req addr          vld ipc           pc_d
    tbl[0]  = mk(0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h4);
    tbl[2]  = mk(0, 0, 32'h0,        1,   1, 32'h4,        1, 32'h0,        32'h8);
    tbl[3]  = mk(0, 0, 32'h0,        1,   1, 32'h8,        1, 32'h4,        32'hC);
    tbl[4]  = mk(0, 0, 32'h0,        0,   1, 32'hC,        1, 32'h8,        32'hC);
    tbl[5]  = mk(0, 0, 32'h0,        0,   1, 32'hC,        0, 32'h0,        32'hC);
    tbl[6]  = mk(0, 0, 32'h0,        1,   1, 32'hC,        0, 32'h0,        32'h10);
    tbl[7]  = mk(1, 0, 32'h0,        1,   1, 32'h10,       1, 32'hC,        32'h14);
    tbl[8]  = mk(1, 0, 32'h0,        0,   0, 32'h14,       1, 32'hC,        32'h14);
    tbl[9]  = mk(1, 0, 32'h0,        0,   0, 32'h14,       1, 32'hC,        32'h14);
    tbl[10] = mk(0, 0, 32'h0,        0,   0, 32'h14,       1, 32'hC,        32'h14);
    tbl[11] = mk(0, 0, 32'h0,        0,   1, 32'h14,       1, 32'h10,       32'h14);
    tbl[12] = mk(0, 0, 32'h0,        1,   1, 32'h14,       0, 32'h0,        32'h18);
    tbl[13] = mk(0, 1, 32'h40,       0,   1, 32'h18,       1, 32'h14,       32'h18);
    tbl[14] = mk(0, 1, 32'h60,       0,   1, 32'h18,       0, 32'h0,        32'h18);
    tbl[15] = mk(0, 0, 32'h0,        1,   1, 32'h18,       0, 32'h0,        32'h60);
    tbl[16] = mk(0, 0, 32'h0,        1,   1, 32'h60,       0, 32'h0,        32'h64);
    tbl[17] = mk(1, 0, 32'h0,        1,   1, 32'h64,       1, 32'h60,       32'h68);
    tbl[18] = mk(1, 1, 32'h80,       0,   0, 32'h68,       1, 32'h60,       32'h80);
    tbl[19] = mk(0, 0, 32'h0,        1,   1, 32'h80,       0, 32'h0,        32'h84);
    tbl[20] = mk(0, 1, 32'hFFFFFFFC, 1,   1, 32'h84,       1, 32'h80,       32'hFFFFFFFC);
    tbl[21] = mk(0, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    tbl[22] = mk(0, 0, 32'h0,        0,   1, 32'h0,        1, 32'hFFFFFFFC, 32'h0);
    tbl[23] = mk(0, 1, 32'h100,      0,   1, 32'h0,        0, 32'h0,        32'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      stall           = tbl[i].stall;
      redirect_valid  = tbl[i].rdv;
      redirect_target = tbl[i].tgt;
      tb_ack          = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("r%0d req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("r%0d addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("r%0d pc_d", i), pc_d, tbl[i].pcd);
      chk($sformatf("r%0d valid", i), 32'(ifid_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("r%0d ifid_pc", i), ifid_pc, tbl[i].ipc);
        chk($sformatf("r%0d ifid_pc4", i), ifid_pc4, tbl[i].ipc + 32'd4);
        chk($sformatf("r%0d instr", i), ifid_instr, memf(tbl[i].ipc));
      end else begin
        chk($sformatf("r%0d bubble", i), ifid_instr, BUBBLE);
      end
      @(posedge clk);
      #1;
    end

    // now in DRAIN with a request outstanding at 0x0
    redirect_valid = 1'b0;
    tb_ack = 1'b0;
    #2;
    chk("drain req", 32'(imem_req), 32'd1);
    chk("drain addr", imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    chk("arst req", 32'(imem_req), 32'd0);
    chk("arst valid", 32'(ifid_valid), 32'd0);
    chk("arst instr", ifid_instr, BUBBLE);
    chk("arst ifid_pc", ifid_pc, 32'h0);
    chk("arst ifid_pc4", ifid_pc4, 32'h0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst pc_d", pc_d, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;

    use_model = 1'b1;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0;
    exp_pc    = 32'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall           = ($urandom_range(3, 0) == 0);
      redirect_valid  = ($urandom_range(15, 0) == 0);
      redirect_target = $urandom & 32'h0000_0FFC;
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        chk("rnd req held", 32'(imem_req), 32'd1);
        chk("rnd addr held", imem_addr, prev_addr);
      end
      if (ifid_valid) begin
        chk("rnd instr", ifid_instr, memf(ifid_pc));
        chk("rnd pc4", ifid_pc4, ifid_pc + 32'd4);
      end else begin
        chk("rnd bubble", ifid_instr, BUBBLE);
      end
      if (redirect_valid) begin
        exp_pc = redirect_target;
      end else if (ifid_valid && !stall) begin
        chk("rnd stream pc", ifid_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      @(posedge clk);
      #1;
    end
    chk("rnd progress", 32'(delivered >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch controller placed around the program-counter register.
- Consumes the PC register's current value and produces its next-value input every cycle. Issues requests to instruction memory over a req/ack handshake and loads the IF/ID pipeline register.
- Handles variable memory latency, downstream stall, and branch/jump redirects, including a redirect that arrives while a memory request is outstanding.

Parameters:
- WORD_W, 32, width of addresses, instructions and PC.
- BUBBLE_INSTR, 32'h00000000, instruction word driven on ifid_instr when ifid_valid=0.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-high reset.
- pc_q, input, WORD_W, current PC (PC register output).
- pc_d, output, WORD_W, next PC (PC register input); the PC register loads it every posedge.
- imem_req, output, 1, fetch request valid.
- imem_addr, output, WORD_W, fetch address.
- imem_ack, input, 1, memory returns imem_rdata this cycle.
- imem_rdata, input, WORD_W, fetched instruction.
- stall, input, 1, decode cannot accept; hold IF/ID.
- redirect_valid, input, 1, branch/jump taken; flush the fetch.
- redirect_target, input, WORD_W, new PC.
- ifid_valid, output, 1, IF/ID holds a real instruction.
- ifid_instr, output, WORD_W, IF/ID instruction.
- ifid_pc, output, WORD_W, address of ifid_instr.
- ifid_pc4, output, WORD_W, ifid_pc+4.

Behaviour:
- FSM states: IDLE, REQ, DRAIN, HOLD.
- Reset (async, rst=1): state=IDLE; ifid_valid=0; ifid_instr=BUBBLE_INSTR; ifid_pc=ifid_pc4=0; skid and pending-target registers 0. The PC register resets to 0 independently.
- pc_d is combinational and defaults to pc_q (hold). It equals pc_q+4 when an instruction is accepted, and the redirect target when a redirect is applied. Adders wrap modulo 2^32 (0xFFFFFFFC+4 = 0).
- imem_addr = pc_q in every state.
- imem_req = 1 in REQ and DRAIN; 0 in IDLE and HOLD.
- Memory rule: once imem_req is high, address stays stable until ack; a request is never withdrawn.
- IDLE: unconditionally goes to REQ on the next posedge (first fetch issues the cycle after reset release).
- REQ, no ack, no redirect: stay in REQ; pc_d=pc_q. If stall=0, IF/ID receives a bubble (ifid_valid<=0).
- REQ, ack, stall=0, no redirect:
  - IF/ID <= {1, imem_rdata, pc_q, pc_q+4}; pc_d=pc_q+4; stay in REQ.
  - A zero-wait memory (ack every cycle) gives 1 instruction/cycle.
- REQ, ack, stall=1, no redirect: capture {imem_rdata, pc_q} in a one-entry skid buffer; pc_d=pc_q+4; go to HOLD; IF/ID unchanged.
- HOLD, stall=1: hold everything. HOLD, stall=0: IF/ID <= skid contents (valid=1), go to REQ.
- Redirect (highest priority, overrides stall): IF/ID flushed on that edge (ifid_valid<=0).
  - In REQ with ack same cycle, or in HOLD: discard the returned/held instruction; pc_d=redirect_target; go to REQ.
  - In REQ without ack: save target in the pending register; pc_d=pc_q; go to DRAIN.
  - In DRAIN: a newer redirect overwrites the pending target.
- DRAIN: keep imem_req=1 at the old address. On ack: discard data; pc_d=pending target, or redirect_target if a redirect arrives the same cycle; go to REQ. IF/ID stays a bubble.
- IF/ID registers update only when stall=0 or on a redirect flush.
- rst mid-operation clears all state immediately. An outstanding memory request is abandoned; memory is reset by the same rst.

Decomposition:
- Shared constants header (the team's constant-values header): WORD_ZERO, PC_INCREMENT (32'd4), the 2-bit FSM encodings FETCH_IDLE/REQ/DRAIN/HOLD, and BUBBLE_INSTR default.
- One natural sub-module: fetch_skid, a one-entry instruction+PC buffer with load/clear/valid.
- The PC register stays a separate instance, wired pc_q/pc_d at the next level up.

Test Plan:
- Zero-wait memory (ack=1 always), release rst at t0 → fetch addresses 0,4,8,12 on consecutive cycles; ifid_pc/ifid_pc4 = 0/4, 4/8, …; ifid_valid=1 from the 2nd cycle after release.
- Memory with 3-cycle ack latency → imem_addr held at 0x8 for 3 cycles; pc_d=pc_q until ack; ifid_valid=0 on non-ack cycles, then instr at 0x8 delivered.
- Ack at 0x10 while stall=1 for 4 cycles → state HOLD, imem_req=0, pc_q=0x14; on stall drop, ifid_instr = data from 0x10 with ifid_pc=0x10, then fetch resumes at 0x14.
- Redirect to 0x40 during outstanding request at 0x20 (ack 2 cycles later) → DRAIN, address stays 0x20, returned word discarded, next fetch at 0x40, no valid 0x20 instruction in IF/ID.
- Redirect and stall both high, held instr present → flush wins: ifid_valid=0, skid cleared, next fetch at target. Second redirect during DRAIN → last target used.
- Assert rst while in DRAIN → all outputs return to reset values asynchronously; first fetch after release at 0x0. Fetch at 0xFFFFFFFC with ack → pc_d=0x0.
